// File: rtl/fmt_packer.sv
// -----------------------------------------------------------------------------
// fmt_packer
//
// Single-channel packet formatter. Sits behind a first-word-fall-through
// channel FIFO and its flag generator. It waits until a full packet of
// cfg_len words is buffered, requests the output arbiter, and once granted
// pops exactly one packet and streams it out as registered beats framed by
// fmt_start / fmt_end.
//
// Optional feature macro: FMT_PARITY_EN
//   When defined, adds fmt_parity, the even parity of each registered beat.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   fifo_rdata     in   FIFO head word (valid whenever fifo_empty = 0)
//   fifo_empty     in   FIFO empty flag
//   fifo_slack     in   FIFO free entries
//   fifo_rd_en     out  pop FIFO head this cycle
//   cfg_len        in   packet length in words (legal 1..MAX_CNT)
//   fmt_req        out  request to arbiter
//   fmt_grant      in   one-cycle grant pulse
//   fmt_chid       out  constant channel id
//   fmt_length     out  length latched for the current packet
//   fmt_send       out  beat valid
//   fmt_data       out  beat payload
//   fmt_start      out  first beat of packet
//   fmt_end        out  last beat of packet
//   fmt_underflow  out  sticky: FIFO ran empty while sending
//   fmt_parity     out  beat parity (FMT_PARITY_EN only)
// -----------------------------------------------------------------------------
module fmt_packer #(
   parameter int         DATA_W   = 32,
   parameter int         PTR_WIDE = 3,
   parameter int         MAX_CNT  = 8,
   parameter logic [1:0] CH_ID    = 2'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   fifo_rdata,
   input  logic                fifo_empty,
   input  logic [PTR_WIDE:0]   fifo_slack,
   output logic                fifo_rd_en,
   input  logic [PTR_WIDE:0]   cfg_len,
   output logic                fmt_req,
   input  logic                fmt_grant,
   output logic [1:0]          fmt_chid,
   output logic [PTR_WIDE:0]   fmt_length,
   output logic                fmt_send,
   output logic [DATA_W-1:0]   fmt_data,
   output logic                fmt_start,
   output logic                fmt_end,
`ifdef FMT_PARITY_EN
   output logic                fmt_underflow,
   output logic                fmt_parity
`else
   output logic                fmt_underflow
`endif
);

   localparam int                LEN_W = PTR_WIDE + 1;
   localparam logic [PTR_WIDE:0] MAX_W = LEN_W'(MAX_CNT);
   localparam logic [PTR_WIDE:0] ONE_W = LEN_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SEND,
      ST_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_WIDE:0]   len_q, len_d;
   logic [PTR_WIDE:0]   cnt_q, cnt_d;
   logic                underflow_q, underflow_d;

   logic                send_q;
   logic [DATA_W-1:0]   data_q;
   logic                start_q;
   logic                end_q;
`ifdef FMT_PARITY_EN
   logic                parity_q;
`endif

   logic [PTR_WIDE:0]   avail;
   logic                len_ok;
   logic                pop;
   logic                first_pop;
   logic                last_pop;

   // A slack above the depth is a corrupted count; treating it as nothing
   // buffered keeps the subtraction from wrapping into a large occupancy.
   assign avail  = (fifo_slack > MAX_W) ? '0 : (MAX_W - fifo_slack);
   assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_W);

   // The counter is loaded with the packet length at grant and only moves on
   // a pop, so "counter still equals length" marks the first pop even when
   // underflow stalls precede it.
   assign first_pop = (cnt_q == len_q);
   assign last_pop  = (cnt_q == ONE_W);

   // NOTE: every signal driven here gets a default before the case so that no
   // path leaves it unassigned; a missing default infers a latch.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      underflow_d = underflow_q;
      pop         = 1'b0;
      fmt_req     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (len_ok && (avail >= cfg_len)) begin
               len_d   = cfg_len;
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            fmt_req = 1'b1;
            if (fmt_grant) begin
               cnt_d   = len_q;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            pop = !fifo_empty;
            if (pop) begin
               cnt_d = cnt_q - ONE_W;
               if (last_pop) begin
                  state_d = ST_DONE;
               end
            end else begin
               underflow_d = 1'b1;
            end
         end

         ST_DONE: begin
            // Final beat is on the registered outputs this cycle.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign fifo_rd_en = pop;
   assign fmt_chid   = CH_ID;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         underflow_q <= 1'b0;
         send_q      <= 1'b0;
         data_q      <= '0;
         start_q     <= 1'b0;
         end_q       <= 1'b0;
`ifdef FMT_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         underflow_q <= underflow_d;
         // Beat registers trail the pop by one cycle; a stall leaves a gap.
         send_q      <= pop;
         data_q      <= pop ? fifo_rdata : '0;
         start_q     <= pop && first_pop;
         end_q       <= pop && last_pop;
`ifdef FMT_PARITY_EN
         parity_q    <= pop ? (^fifo_rdata) : 1'b0;
`endif
      end
   end

   assign fmt_length    = len_q;
   assign fmt_send      = send_q;
   assign fmt_data      = data_q;
   assign fmt_start     = start_q;
   assign fmt_end       = end_q;
   assign fmt_underflow = underflow_q;
`ifdef FMT_PARITY_EN
   assign fmt_parity    = parity_q;
`endif

endmodule

// File: tb/tb_fmt_packer.sv
// -----------------------------------------------------------------------------
// tb_fmt_packer
//
// Directed bench for fmt_packer. The FIFO head word is generated as
// base + pop_count, so consecutive pops present consecutive words; slack and
// empty are driven directly. Inputs are driven and outputs sampled 1 ns after
// each rising edge. Parity checks are compiled in with FMT_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_fmt_packer;

   localparam int DATA_W   = 32;
   localparam int PTR_WIDE = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [DATA_W-1:0]   fifo_rdata;
   logic                fifo_empty;
   logic [PTR_WIDE:0]   fifo_slack;
   logic                fifo_rd_en;
   logic [PTR_WIDE:0]   cfg_len;
   logic                fmt_req;
   logic                fmt_grant;
   logic [1:0]          fmt_chid;
   logic [PTR_WIDE:0]   fmt_length;
   logic                fmt_send;
   logic [DATA_W-1:0]   fmt_data;
   logic                fmt_start;
   logic                fmt_end;
   logic                fmt_underflow;
`ifdef FMT_PARITY_EN
   logic                fmt_parity;
`endif

   logic [31:0]         base;
   logic [31:0]         pop_cnt = 32'd0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_rd_en) pop_cnt <= pop_cnt + 32'd1;
   end

   assign fifo_rdata = base + pop_cnt;

   fmt_packer #(
      .DATA_W   (DATA_W),
      .PTR_WIDE (PTR_WIDE),
      .MAX_CNT  (8),
      .CH_ID    (2'd2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_rdata    (fifo_rdata),
      .fifo_empty    (fifo_empty),
      .fifo_slack    (fifo_slack),
      .fifo_rd_en    (fifo_rd_en),
      .cfg_len       (cfg_len),
      .fmt_req       (fmt_req),
      .fmt_grant     (fmt_grant),
      .fmt_chid      (fmt_chid),
      .fmt_length    (fmt_length),
      .fmt_send      (fmt_send),
      .fmt_data      (fmt_data),
      .fmt_start     (fmt_start),
      .fmt_end       (fmt_end),
`ifdef FMT_PARITY_EN
      .fmt_underflow (fmt_underflow),
      .fmt_parity    (fmt_parity)
`else
      .fmt_underflow (fmt_underflow)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset held over an edge, then released; leaves the bench 1 ns after the edge.
   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // One single-word packet carrying word w; checks payload and, if built in, parity.
   task automatic single_word(input logic [31:0] w, input logic exp_par);
      cfg_len    = 4'd1;
      fifo_slack = 4'd7;
      fifo_empty = 1'b0;
      base       = w - pop_cnt;
      step();                                   // REQ
      fmt_grant = 1'b1;
      step();                                   // SEND
      fmt_grant  = 1'b0;
      fifo_slack = 4'd8;
      step();                                   // DONE: beat visible
      check("par_pkt_data", fmt_data, w);
`ifdef FMT_PARITY_EN
      check("par_value", {31'd0, fmt_parity}, {31'd0, exp_par});
`else
      if (exp_par) begin end
`endif
      step();                                   // IDLE
`ifdef FMT_PARITY_EN
      check("par_idle_zero", {31'd0, fmt_parity}, 32'd0);
`endif
   endtask

   initial begin
      rst_n      = 1'b0;
      fifo_empty = 1'b1;
      fifo_slack = 4'd8;
      cfg_len    = 4'd4;
      fmt_grant  = 1'b0;
      base       = 32'd0;

      // ---------------- reset state ----------------
      step();
      step();
      check("rst_req",       {31'd0, fmt_req},       32'd0);
      check("rst_rd_en",     {31'd0, fifo_rd_en},    32'd0);
      check("rst_send",      {31'd0, fmt_send},      32'd0);
      check("rst_start",     {31'd0, fmt_start},     32'd0);
      check("rst_end",       {31'd0, fmt_end},       32'd0);
      check("rst_data",      fmt_data,               32'd0);
      check("rst_length",    {28'd0, fmt_length},    32'd0);
      check("rst_underflow", {31'd0, fmt_underflow}, 32'd0);
      check("rst_chid",      {30'd0, fmt_chid},      32'd2);
      rst_n = 1'b1;

      // ---------------- L=4 packet, slack 8 -> 4 ----------------
      step();
      step();
      check("l4_no_req_empty", {31'd0, fmt_req}, 32'd0);
      fifo_slack = 4'd4;
      fifo_empty = 1'b0;
      base       = 32'hA0 - pop_cnt;
      #1;
      check("l4_req_not_yet", {31'd0, fmt_req}, 32'd0);
      step();
      check("l4_req_rise", {31'd0, fmt_req},    32'd1);
      check("l4_length",   {28'd0, fmt_length}, 32'd4);
      cfg_len = 4'd2;                           // must not affect this packet
      step();
      check("l4_req_hold", {31'd0, fmt_req},    32'd1);
      check("l4_no_pop_in_req", {31'd0, fifo_rd_en}, 32'd0);
      fmt_grant = 1'b1;
      step();                                   // cycle G
      fmt_grant = 1'b0;
      check("l4_req_drop",  {31'd0, fmt_req},  32'd0);
      check("l4_send_at_G", {31'd0, fmt_send}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("l4_rd_en", {31'd0, fifo_rd_en}, 32'd1);
         step();
         check("l4_send",  {31'd0, fmt_send},  32'd1);
         check("l4_data",  fmt_data,           32'hA0 + 32'(i));
         check("l4_start", {31'd0, fmt_start}, (i == 0) ? 32'd1 : 32'd0);
         check("l4_end",   {31'd0, fmt_end},   (i == 3) ? 32'd1 : 32'd0);
      end
`ifdef FMT_PARITY_EN
      check("l4_par_a3", {31'd0, fmt_parity}, 32'd0);
`endif
      // cycle G+4: DONE
      check("l4_done_rd_en",  {31'd0, fifo_rd_en}, 32'd0);
      check("l4_done_length", {28'd0, fmt_length}, 32'd4);
      check("l4_pops",        pop_cnt,             32'd4);
      fifo_slack = 4'd8;
      step();
      check("l4_idle_send", {31'd0, fmt_send}, 32'd0);
      check("l4_idle_req",  {31'd0, fmt_req},  32'd0);
      check("l4_no_underflow", {31'd0, fmt_underflow}, 32'd0);

      // ---------------- L=1 packet, slack 7 ----------------
      cfg_len    = 4'd1;
      fifo_slack = 4'd7;
      base       = 32'hB0 - pop_cnt;
      step();
      check("l1_req", {31'd0, fmt_req}, 32'd1);
      fmt_grant = 1'b1;
      step();                                   // G: SEND
      fmt_grant = 1'b0;
      check("l1_rd_en", {31'd0, fifo_rd_en}, 32'd1);
      step();                                   // G+1: DONE
      check("l1_send",   {31'd0, fmt_send},   32'd1);
      check("l1_data",   fmt_data,            32'hB0);
      check("l1_start",  {31'd0, fmt_start},  32'd1);
      check("l1_end",    {31'd0, fmt_end},    32'd1);
      check("l1_length", {28'd0, fmt_length}, 32'd1);
      check("l1_done_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      step();                                   // G+2: IDLE
      check("l1_gap_req",   {31'd0, fmt_req},  32'd0);
      check("l1_gap_send",  {31'd0, fmt_send}, 32'd0);
      step();                                   // G+3: REQ again
      check("l1_rereq", {31'd0, fmt_req}, 32'd1);
      fifo_slack = 4'd8;
      do_reset();
      check("l1_rst_req", {31'd0, fmt_req}, 32'd0);

      // ---------------- invalid lengths, avail = 8 ----------------
      fifo_slack = 4'd0;
      cfg_len    = 4'd0;
      for (int i = 0; i < 20; i++) begin
         fmt_grant = (i == 5);                  // grant outside REQ is ignored
         step();
         check("len0_no_req", {31'd0, fmt_req},    32'd0);
         check("len0_no_pop", {31'd0, fifo_rd_en}, 32'd0);
      end
      fmt_grant = 1'b0;
      cfg_len   = 4'd9;
      for (int i = 0; i < 20; i++) begin
         step();
         check("len9_no_req", {31'd0, fmt_req}, 32'd0);
      end
      check("len_inv_length", {28'd0, fmt_length}, 32'd0);
      fifo_slack = 4'd8;
      cfg_len    = 4'd4;
      step();

      // ---------------- underflow stall mid-SEND, L=4 ----------------
      fifo_slack = 4'd4;
      base       = 32'hC0 - pop_cnt;
      step();                                   // REQ
      fmt_grant = 1'b1;
      step();                                   // G: pop C0
      fmt_grant = 1'b0;
      check("uf_rd_en_G", {31'd0, fifo_rd_en}, 32'd1);
      step();                                   // G+1
      fifo_empty = 1'b1;
      #1;
      check("uf_no_pop",   {31'd0, fifo_rd_en}, 32'd0);
      check("uf_beat0",    fmt_data,            32'hC0);
      check("uf_start0",   {31'd0, fmt_start},  32'd1);
      step();                                   // G+2: gap
      fifo_empty = 1'b0;
      check("uf_flag",     {31'd0, fmt_underflow}, 32'd1);
      check("uf_gap_send", {31'd0, fmt_send},      32'd0);
      for (int i = 1; i < 4; i++) begin
         step();
         check("uf_send",  {31'd0, fmt_send},  32'd1);
         check("uf_data",  fmt_data,           32'hC0 + 32'(i));
         check("uf_start", {31'd0, fmt_start}, 32'd0);
         check("uf_end",   {31'd0, fmt_end},   (i == 3) ? 32'd1 : 32'd0);
      end
      check("uf_done_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      fifo_slack = 4'd8;
      step();
      check("uf_sticky", {31'd0, fmt_underflow}, 32'd1);
      check("uf_idle_send", {31'd0, fmt_send}, 32'd0);

      // ---------------- reset mid-SEND after 2 pops ----------------
      fifo_slack = 4'd4;
      base       = 32'hD0 - pop_cnt;
      step();                                   // REQ
      fmt_grant = 1'b1;
      step();                                   // G: pop 1
      fmt_grant = 1'b0;
      step();                                   // G+1: pop 2
      check("mrst_rd_en", {31'd0, fifo_rd_en}, 32'd1);
      rst_n      = 1'b0;
      fifo_slack = 4'd8;
      step();
      rst_n = 1'b1;
      check("mrst_rd_en0",     {31'd0, fifo_rd_en},    32'd0);
      check("mrst_send",       {31'd0, fmt_send},      32'd0);
      check("mrst_req",        {31'd0, fmt_req},       32'd0);
      check("mrst_underflow",  {31'd0, fmt_underflow}, 32'd0);
      check("mrst_length",     {28'd0, fmt_length},    32'd0);
      step();
      check("mrst_idle_req",   {31'd0, fmt_req},       32'd0);

      // ---------------- parity words ----------------
      single_word(32'h0000_0003, 1'b0);
      single_word(32'h0000_0007, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
